// File: rtl/mem_line_responder.sv
// Memory-side line responder for cache refill and write-back requests.
// Answers each captured request with one ready_mem pulse a fixed LATENCY edges later.
module mem_line_responder #(
   parameter int ADDR_WIDTH = 8,
   parameter int LINE_WIDTH = 128,
   parameter int LATENCY    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  read_en_mem,
   input  logic                  write_en_mem,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [LINE_WIDTH-1:0] mem_wdata,
   output logic [LINE_WIDTH-1:0] mem_rdata,
   output logic                  ready_mem,
   output logic                  mem_busy,
   output logic                  proto_err
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

   generate
      if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
         $error("mem_line_responder: LATENCY must be in 1..255");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP,
      RELEASE
   } state_t;

   state_t state;
   state_t next_state;

   logic [7:0]            cnt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LINE_WIDTH-1:0] wdata_q;
   logic                  op_write_q;
   logic [LINE_WIDTH-1:0] mem_array [0:DEPTH-1];

   logic any_req;
   logic op_active;
   logic capture;
   logic abort;
   logic resp_entry;

   // op_active tracks the enable belonging to the latched operation only
   assign any_req    = read_en_mem | write_en_mem;
   assign op_active  = op_write_q ? write_en_mem : read_en_mem;
   assign capture    = (state == IDLE) && any_req;
   assign abort      = (state == WAIT) && !op_active;
   assign resp_entry = (state == WAIT) && op_active && (cnt == 8'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (any_req) begin
               next_state = WAIT;
            end
         end
         WAIT: begin
            if (!op_active) begin
               next_state = IDLE;
            end else if (cnt == 8'd0) begin
               next_state = RESP;
            end
         end
         RESP: begin
            next_state = any_req ? RELEASE : IDLE;
         end
         RELEASE: begin
            if (!any_req) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_comb begin
      ready_mem = (state == RESP);
      mem_busy  = (state != IDLE);
   end

   // Request capture, latency countdown and response data register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= 8'd0;
         addr_q     <= '0;
         wdata_q    <= '0;
         op_write_q <= 1'b0;
         mem_rdata  <= '0;
         proto_err  <= 1'b0;
      end else begin
         proto_err <= (capture && read_en_mem && write_en_mem) || abort;
         if (capture) begin
            addr_q     <= mem_addr;
            wdata_q    <= mem_wdata;
            op_write_q <= write_en_mem;
            cnt        <= CNT_INIT;
         end else if ((state == WAIT) && op_active && (cnt != 8'd0)) begin
            cnt <= cnt - 8'd1;
         end
         if (resp_entry) begin
            mem_rdata <= op_write_q ? wdata_q : mem_array[addr_q];
         end
      end
   end

   // Line storage is never cleared; reset forces IDLE so an in-flight write is dropped
   always_ff @(posedge clk) begin
      if (resp_entry && op_write_q) begin
         mem_array[addr_q] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_mem_line_responder.sv
// Scoreboard bench for mem_line_responder: expected line data is queued when a
// request is issued and compared when ready_mem is observed.
module tb_mem_line_responder;

   localparam int AW  = 8;
   localparam int LW  = 128;
   localparam int LAT = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          read_en_mem = 1'b0;
   logic          write_en_mem = 1'b0;
   logic [AW-1:0] mem_addr = '0;
   logic [LW-1:0] mem_wdata = '0;
   logic [LW-1:0] mem_rdata;
   logic          ready_mem;
   logic          mem_busy;
   logic          proto_err;

   int checks = 0;
   int errors = 0;
   int ready_count = 0;
   logic [LW-1:0] sb_q[$];
   logic [LW-1:0] model [0:255];

   mem_line_responder #(
      .ADDR_WIDTH(AW),
      .LINE_WIDTH(LW),
      .LATENCY(LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .read_en_mem(read_en_mem),
      .write_en_mem(write_en_mem),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .ready_mem(ready_mem),
      .mem_busy(mem_busy),
      .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Every ready pulse must match the oldest outstanding request
   always @(negedge clk) begin
      if (!rst && ready_mem) begin
         ready_count++;
         if (sb_q.size() == 0) begin
            check_output("ready_without_request", 128'(ready_mem), 128'(0));
         end else begin
            check_output("resp_data", mem_rdata, sb_q.pop_front());
         end
      end
   end

   task automatic apply_stimulus(input logic rd, input logic wr, input logic [AW-1:0] addr,
                                 input logic [LW-1:0] data, input int hold, input logic exp_perr);
      logic [LW-1:0] exp_data;
      int            start_cnt;
      int            i;
      logic          perr1;
      logic          perr2;
      @(negedge clk);
      read_en_mem  = rd;
      write_en_mem = wr;
      mem_addr     = addr;
      mem_wdata    = data;
      if (wr) begin
         model[addr] = data;
         exp_data    = data;
      end else begin
         exp_data = model[addr];
      end
      sb_q.push_back(exp_data);
      start_cnt = ready_count;
      i = 0;
      perr1 = 1'b0;
      perr2 = 1'b0;
      do begin
         @(negedge clk);
         i++;
         if (i == 1) perr1 = proto_err;
         if (i == 2) perr2 = proto_err;
      end while (!ready_mem && i < 20);
      check_output("latency", 128'(i), 128'(LAT + 1));
      check_output("proto_err_capture", 128'(perr1), 128'(exp_perr));
      check_output("proto_err_pulse_width", 128'(perr2), 128'(0));
      repeat (hold) begin
         @(negedge clk);
         check_output("release_ready", 128'(ready_mem), 128'(0));
         check_output("release_busy", 128'(mem_busy), 128'(1));
      end
      read_en_mem  = 1'b0;
      write_en_mem = 1'b0;
      @(negedge clk);
      check_output("idle_busy", 128'(mem_busy), 128'(0));
      check_output("ready_pulse_count", 128'(ready_count - start_cnt), 128'(1));
   endtask

   localparam logic [LW-1:0] OLD05 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_0505;
   localparam logic [LW-1:0] NEW05 = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
   localparam logic [LW-1:0] PAT_A5 = {16{8'hA5}};
   localparam logic [LW-1:0] BOTH_D = 128'h0BAD_CAFE_0123_4567_89AB_CDEF_5A5A_0020;

   initial begin
      int start_cnt;
      repeat (2) @(negedge clk);
      check_output("reset_ready", 128'(ready_mem), 128'(0));
      check_output("reset_rdata", mem_rdata, 128'(0));
      check_output("reset_busy", 128'(mem_busy), 128'(0));
      check_output("reset_proto_err", 128'(proto_err), 128'(0));
      rst = 1'b0;

      // Reset in the middle of a write must drop it
      apply_stimulus(1'b0, 1'b1, 8'h05, OLD05, 0, 1'b0);
      @(negedge clk);
      write_en_mem = 1'b1;
      mem_addr     = 8'h05;
      mem_wdata    = NEW05;
      @(negedge clk);
      @(negedge clk);
      check_output("wait_busy", 128'(mem_busy), 128'(1));
      rst = 1'b1;
      #1;
      check_output("midreset_ready", 128'(ready_mem), 128'(0));
      check_output("midreset_rdata", mem_rdata, 128'(0));
      check_output("midreset_busy", 128'(mem_busy), 128'(0));
      check_output("midreset_proto_err", 128'(proto_err), 128'(0));
      write_en_mem = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      apply_stimulus(1'b1, 1'b0, 8'h05, '0, 0, 1'b0);

      // Preload then read back the A5 pattern
      apply_stimulus(1'b0, 1'b1, 8'h10, PAT_A5, 0, 1'b0);
      apply_stimulus(1'b1, 1'b0, 8'h10, '0, 0, 1'b0);

      // Write then read 0x3F
      apply_stimulus(1'b0, 1'b1, 8'h3F, 128'h1234, 0, 1'b0);
      apply_stimulus(1'b1, 1'b0, 8'h3F, '0, 0, 1'b0);

      // Held enable stays in RELEASE
      apply_stimulus(1'b1, 1'b0, 8'h3F, '0, 3, 1'b0);

      // Both enables: write wins and proto_err pulses
      apply_stimulus(1'b1, 1'b1, 8'h20, BOTH_D, 0, 1'b1);
      apply_stimulus(1'b1, 1'b0, 8'h20, '0, 0, 1'b0);

      // Abort two cycles into WAIT
      start_cnt = ready_count;
      @(negedge clk);
      read_en_mem = 1'b1;
      mem_addr    = 8'h10;
      @(negedge clk);
      @(negedge clk);
      read_en_mem = 1'b0;
      @(negedge clk);
      check_output("abort_proto_err", 128'(proto_err), 128'(1));
      check_output("abort_busy", 128'(mem_busy), 128'(0));
      @(negedge clk);
      check_output("abort_proto_err_width", 128'(proto_err), 128'(0));
      repeat (6) @(negedge clk);
      check_output("abort_no_ready", 128'(ready_count - start_cnt), 128'(0));
      check_output("rdata_hold", mem_rdata, BOTH_D);

      check_output("scoreboard_drained", 128'(sb_q.size()), 128'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
